// File: rtl/seq_stream_tx_pkg.sv
// Shared constants and state types for the serial "1001" stream source.
// Pulled in by the interface, the tracker and the top.
package seq_stream_tx_pkg;

    localparam int WORD_W  = 8;
    localparam int BIT_W   = $clog2(WORD_W);
    localparam int PAT_LEN = 4;
    localparam int CNT_W   = 8;

    localparam logic [PAT_LEN-1:0] PATTERN = 4'b1001;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    typedef enum logic [1:0] {
        S0,
        S1,
        S10,
        S100
    } trk_state_t;

endpackage

// File: rtl/seq_stream_tx_if.sv
// Parallel-word valid/ready handshake feeding the serializer.
// The producer drives valid/word, the serializer drives ready.
interface seq_stream_tx_if;
    import seq_stream_tx_pkg::*;

    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_word,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_word,
        output in_ready
    );

endinterface

// File: rtl/seq_pattern_model.sv
// Non-overlapping Mealy tracker for the "1001" pattern on the serial line.
// Samples every cycle, idle fill included, like the detector it mirrors.
module seq_pattern_model
    import seq_stream_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       data,
    output logic       exp_det,
    output trk_state_t state
);

    trk_state_t state_q;
    trk_state_t state_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // a stray 1 mid-pattern restarts the match from S1
    always_comb begin
        state_d = state_q;
        exp_det = 1'b0;
        unique case (state_q)
            S0: begin
                state_d = (data == PATTERN[3]) ? S1 : S0;
            end
            S1: begin
                state_d = (data == PATTERN[2]) ? S10 : S1;
            end
            S10: begin
                state_d = (data == PATTERN[1]) ? S100 : S1;
            end
            S100: begin
                exp_det = (data == PATTERN[0]);
                state_d = S0;
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/seq_stream_tx.sv
// MSB-first word serializer with a reference "1001" tracker and a
// saturating match counter for checking a downstream detector.
module seq_stream_tx
    import seq_stream_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    seq_stream_tx_if.slave   up,
    input  logic             cnt_clr,
    output logic             data,
    output logic             data_valid,
    output logic             exp_det,
    output logic [CNT_W-1:0] exp_count
);

    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ready;
    logic              hs;
    trk_state_t        trk_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // a word accepted on the last bit follows with no idle gap
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ready      = 1'b0;
        data       = 1'b0;
        data_valid = 1'b0;
        hs         = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                data       = shreg_q[WORD_W-1];
                data_valid = 1'b1;
                ready      = (bit_cnt_q == '0);
                shreg_d    = shreg_q << 1;
                bit_cnt_d  = bit_cnt_q - 1'b1;
                if (bit_cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hs = up.in_valid && ready;
        if (hs) begin
            state_d   = SHIFT;
            shreg_d   = up.in_word;
            bit_cnt_d = BIT_W'(WORD_W - 1);
        end
    end

    assign up.in_ready = ready;

    seq_pattern_model u_trk (
        .clk     (clk),
        .rstn    (rstn),
        .data    (data),
        .exp_det (exp_det),
        .state   (trk_state)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (exp_det && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign exp_count = cnt_q;

    det_only_in_s100: assert property (
        @(posedge clk) disable iff (!rstn)
        exp_det |-> (trk_state == S100)
    );

endmodule

// File: tb/tb_seq_stream_tx.sv
// Randomized and directed bench for seq_stream_tx against a queue-based
// serializer model and a sliding-window "1001" detector.
module tb_seq_stream_tx;

    logic       clk;
    logic       rstn;
    logic       cnt_clr;
    logic       data;
    logic       data_valid;
    logic       exp_det;
    logic [7:0] exp_count;

    seq_stream_tx_if sif ();

    seq_stream_tx dut (
        .clk        (clk),
        .rstn       (rstn),
        .up         (sif.slave),
        .cnt_clr    (cnt_clr),
        .data       (data),
        .data_valid (data_valid),
        .exp_det    (exp_det),
        .exp_count  (exp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    bit       mq[$];
    int       since;
    bit [2:0] hist;
    int       mcnt;
    bit       last_hs;
    int       run;
    int       max_run;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_data();
        return (mq.size() > 0) ? mq[0] : 1'b0;
    endfunction

    function automatic bit m_valid();
        return mq.size() > 0;
    endfunction

    function automatic bit m_ready();
        return mq.size() <= 1;
    endfunction

    // match when the three bits since the last match end in 100
    function automatic bit m_det();
        return since >= 3 && hist == 3'b100 && m_data();
    endfunction

    task automatic model_reset();
        mq.delete();
        since = 0;
        hist  = 3'b000;
        mcnt  = 0;
    endtask

    task automatic model_step();
        bit d;
        bit det;
        bit hs;
        last_hs = 1'b0;
        if (!rstn) begin
            model_reset();
            return;
        end
        d   = m_data();
        det = m_det();
        hs  = sif.in_valid && m_ready();
        if (mq.size() > 0) void'(mq.pop_front());
        if (hs) begin
            for (int i = 7; i >= 0; i--) mq.push_back(sif.in_word[i]);
        end
        last_hs = hs;
        if (det) begin
            since = 0;
            hist  = 3'b000;
        end else begin
            hist  = {hist[1:0], d};
            since = (since < 3) ? since + 1 : 3;
        end
        if (cnt_clr) mcnt = 0;
        else if (det && mcnt < 255) mcnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        check("data", {31'd0, data}, {31'd0, m_data()});
        check("valid", {31'd0, data_valid}, {31'd0, m_valid()});
        check("ready", {31'd0, sif.in_ready}, {31'd0, m_ready()});
        check("det", {31'd0, exp_det}, {31'd0, m_det()});
        check("count", {24'd0, exp_count}, mcnt);
        if (data_valid) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] w, input bit hold);
        int k;
        sif.in_valid = 1'b1;
        sif.in_word  = w;
        k = 0;
        do begin
            tick();
            k++;
        end while (!last_hs && k < 20);
        if (!last_hs) check("hs_timeout", 0, 1);
        if (!hold) sif.in_valid = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    logic [7:0] dp;
    int         tail;

    initial begin
        n_chk = 0;
        n_fail = 0;
        run = 0;
        max_run = 0;
        rstn = 1'b0;
        cnt_clr = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_word = 8'h00;
        model_reset();
        #1;
        check("rst_data", {31'd0, data}, 0);
        check("rst_valid", {31'd0, data_valid}, 0);
        check("rst_ready", {31'd0, sif.in_ready}, 1);
        check("rst_det", {31'd0, exp_det}, 0);
        check("rst_count", {24'd0, exp_count}, 0);
        ticks(2);
        rstn = 1'b1;
        ticks(4);

        // single 0x99 from idle
        send(8'h99, 1'b0);
        dp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            dp = {dp[6:0], exp_det};
            tick();
        end
        check("x99_det_bits", {24'd0, dp}, 32'h11);
        check("x99_count", {24'd0, exp_count}, 2);
        ticks(4);

        // reset mid-word on bit 3 of 0xFF, with a word offered meanwhile
        send(8'hFF, 1'b0);
        ticks(2);
        #2;
        rstn = 1'b0;
        sif.in_valid = 1'b1;
        sif.in_word = 8'hA5;
        model_reset();
        #1;
        check("mid_rst_data", {31'd0, data}, 0);
        check("mid_rst_valid", {31'd0, data_valid}, 0);
        check("mid_rst_ready", {31'd0, sif.in_ready}, 1);
        check("mid_rst_count", {24'd0, exp_count}, 0);
        ticks(2);
        rstn = 1'b1;
        sif.in_valid = 1'b0;
        tail = 0;
        for (int i = 0; i < 12; i++) begin
            if (data_valid) tail++;
            tick();
        end
        check("mid_rst_tail", tail, 0);

        // back-to-back 0x90 0x90 with valid held
        clear_cnt();
        ticks(3);
        max_run = 0;
        send(8'h90, 1'b1);
        send(8'h90, 1'b0);
        ticks(10);
        check("b2b_run", max_run, 16);
        check("b2b_count", {24'd0, exp_count}, 2);

        // 0x01, two idle cycles, then 0x80
        clear_cnt();
        ticks(3);
        send(8'h01, 1'b0);
        ticks(9);
        sif.in_valid = 1'b1;
        sif.in_word = 8'h80;
        tick();
        sif.in_valid = 1'b0;
        check("span_hs", {31'd0, last_hs}, 1);
        check("span_det", {31'd0, exp_det}, 1);
        ticks(10);
        check("span_count", {24'd0, exp_count}, 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            sif.in_valid = ($urandom_range(0, 9) < 6);
            sif.in_word = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                sif.in_word = ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h90;
            cnt_clr = ($urandom_range(0, 59) == 0);
            tick();
        end
        sif.in_valid = 1'b0;
        cnt_clr = 1'b0;
        ticks(12);

        // saturation, then a clear on a match cycle
        clear_cnt();
        for (int i = 0; i < 256; i++) send(8'h90, 1'b1);
        sif.in_valid = 1'b0;
        ticks(12);
        check("sat_count", {24'd0, exp_count}, 255);
        send(8'h90, 1'b0);
        ticks(3);
        check("clr_on_det", {31'd0, exp_det}, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_wins", {24'd0, exp_count}, 0);
        ticks(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
